lcd_char_writer: RTL and testbench



---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_char_writer_if.sv | 12 +
 rtl/lcd_byte_tx.sv | 58 +++++
 rtl/lcd_char_writer.sv | 160 ++++++++++++++++
 tb/tb_lcd_char_writer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - FSM states, HD44780 command codes and init sequence lookup
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_CLEAR,
    ST_ADDR,
    ST_DATA,
    ST_SKIP
  } lcd_state_t;

  localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_CLEAR;
      default: return LCD_ENTRY;
    endcase
  endfunction

  // Row 1 starts at DDRAM address 0x40 on a 16x2 panel.
  function automatic logic [7:0] addr_cmd(input logic [4:0] pos);
    return LCD_SET_DDRAM | {1'b0, pos[4], 2'b00, pos[3:0]};
  endfunction

endpackage

// File: rtl/lcd_char_writer_if.sv
// rtl/lcd_char_writer_if.sv - character write / clear request handshake
interface lcd_char_writer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_row;
  logic [3:0] wr_col;
  logic [7:0] wr_char;
  logic       clr_req;

  modport master (output wr_valid, wr_row, wr_col, wr_char, clr_req, input wr_ready);
  modport slave  (input wr_valid, wr_row, wr_col, wr_char, clr_req, output wr_ready);
endinterface

// File: rtl/lcd_byte_tx.sv
// rtl/lcd_byte_tx.sv - one LCD bus byte: setup, EN pulse, then command wait
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 2,
  parameter int EN_CYC         = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       tx_rs,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);
  localparam int CNT_W = $clog2(SETUP_CYC + EN_CYC + CLEAR_WAIT_CYC + 1);

  logic             busy;
  logic             long_wait;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] last;

  assign cnt_nxt = cnt + 1'b1;
  assign last    = long_wait ? CNT_W'(SETUP_CYC + EN_CYC + CLEAR_WAIT_CYC - 1)
                             : CNT_W'(SETUP_CYC + EN_CYC + CMD_WAIT_CYC - 1);
  // done marks the last wait cycle so the next byte can start right after it.
  assign done    = busy && (cnt == last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      long_wait <= 1'b0;
      cnt       <= '0;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_data  <= 8'h00;
    end else if (start) begin
      busy      <= 1'b1;
      long_wait <= !tx_rs && (tx_byte == LCD_CLEAR);
      cnt       <= '0;
      lcd_rs    <= tx_rs;
      lcd_data  <= tx_byte;
      lcd_en    <= (SETUP_CYC == 0);
    end else if (busy) begin
      cnt    <= cnt_nxt;
      lcd_en <= (cnt_nxt >= CNT_W'(SETUP_CYC)) && (cnt_nxt < CNT_W'(SETUP_CYC + EN_CYC));
      if (done) begin
        busy   <= 1'b0;
        lcd_en <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/lcd_char_writer.sv
// rtl/lcd_char_writer.sv - HD44780 16x2 positioned character writer with cursor tracking
// LCD_SHADOW_EN adds a 32-entry display shadow that suppresses writes of unchanged characters.
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 2,
  parameter int EN_CYC         = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic               clk,
  input  logic               reset_n,
  lcd_char_writer_if.slave   wr,
  output logic               LCD_RS,
  output logic               LCD_RW,
  output logic               LCD_EN,
  output logic               LCD_ON,
  output logic               LCD_BLON,
  output logic [7:0]         LCD_DATA
);
  localparam int PWR_MAX = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
  localparam int PWR_W   = $clog2(PWR_MAX + 1);

  lcd_state_t       state, state_next;
  logic [PWR_W-1:0] pwr_cnt;
  logic [1:0]       init_idx;
  logic [4:0]       pos_q;
  logic [7:0]       char_q;
  logic             cur_valid;
  logic [4:0]       cur_pos;
  logic [4:0]       target;
  logic             tx_start, tx_rs, tx_done, accept, shadow_hit;
  logic [7:0]       tx_byte;

  assign target      = {wr.wr_row, wr.wr_col};
  assign wr.wr_ready = (state == ST_IDLE);
  assign LCD_RW      = 1'b0;
  assign LCD_ON      = 1'b1;
  assign LCD_BLON    = 1'b1;

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    tx_byte    = 8'h00;
    tx_rs      = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_PWRUP: if (pwr_cnt == PWR_W'(POWERUP_CYC)) begin
        state_next = ST_INIT;
        tx_start   = 1'b1;
        tx_byte    = init_cmd(2'd0);
      end
      ST_INIT: if (tx_done) begin
        if (init_idx == 2'd3) begin
          state_next = ST_IDLE;
        end else begin
          tx_start = 1'b1;
          tx_byte  = init_cmd(init_idx + 2'd1);
        end
      end
      ST_IDLE: if (wr.clr_req) begin
        state_next = ST_CLEAR;
        tx_start   = 1'b1;
        tx_byte    = LCD_CLEAR;
      end else if (wr.wr_valid) begin
        accept = 1'b1;
        if (shadow_hit) begin
          state_next = ST_SKIP;
        end else if (cur_valid && (cur_pos == target)) begin
          state_next = ST_DATA;
          tx_start   = 1'b1;
          tx_byte    = wr.wr_char;
          tx_rs      = 1'b1;
        end else begin
          state_next = ST_ADDR;
          tx_start   = 1'b1;
          tx_byte    = addr_cmd(target);
        end
      end
      ST_ADDR: if (tx_done) begin
        state_next = ST_DATA;
        tx_start   = 1'b1;
        tx_byte    = char_q;
        tx_rs      = 1'b1;
      end
      ST_CLEAR, ST_DATA: if (tx_done) state_next = ST_IDLE;
      ST_SKIP:  state_next = ST_IDLE;
      default:  state_next = ST_PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_PWRUP;
      pwr_cnt   <= '0;
      init_idx  <= 2'd0;
      pos_q     <= '0;
      char_q    <= 8'h00;
      cur_valid <= 1'b0;
      cur_pos   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_PWRUP && state_next == ST_PWRUP) pwr_cnt <= pwr_cnt + 1'b1;
      if (state == ST_INIT && tx_start) init_idx <= init_idx + 2'd1;
      if (accept) begin
        pos_q  <= target;
        char_q <= wr.wr_char;
      end
      if (state == ST_ADDR && tx_done) begin
        cur_valid <= 1'b1;
        cur_pos   <= pos_q;
      end
      // The panel auto-increments; past column 15 it leaves the visible row.
      if (state == ST_DATA && tx_done) begin
        cur_pos[3:0] <= cur_pos[3:0] + 4'd1;
        if (cur_pos[3:0] == 4'hF) cur_valid <= 1'b0;
      end
      if (state == ST_CLEAR && tx_done) cur_valid <= 1'b0;
    end
  end

`ifdef LCD_SHADOW_EN
  logic [7:0] shadow [32];
  logic       shadow_fill;

  assign shadow_fill = (state == ST_PWRUP && state_next == ST_INIT) ||
                       (state == ST_IDLE && state_next == ST_CLEAR);
  assign shadow_hit  = (shadow[target] == wr.wr_char);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
    end else if (shadow_fill) begin
      for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
    end else if (state == ST_DATA && tx_done) begin
      shadow[pos_q] <= char_q;
    end
  end
`else
  assign shadow_hit = 1'b0;
`endif

  lcd_byte_tx #(
    .SETUP_CYC      (SETUP_CYC),
    .EN_CYC         (EN_CYC),
    .CMD_WAIT_CYC   (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
  ) u_byte_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (tx_start),
    .tx_byte  (tx_byte),
    .tx_rs    (tx_rs),
    .done     (tx_done),
    .lcd_rs   (LCD_RS),
    .lcd_en   (LCD_EN),
    .lcd_data (LCD_DATA)
  );
endmodule

// File: tb/tb_lcd_char_writer.sv
// tb/tb_lcd_char_writer.sv - self-checking bench for lcd_char_writer against a request-level model
module tb_lcd_char_writer;
  localparam int P_PWR = 100, P_SET = 2, P_EN = 4, P_CMD = 10, P_CLR = 50;
  localparam int L_CMD = P_SET + P_EN + P_CMD;
  localparam int L_CLR = P_SET + P_EN + P_CLR;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
    int         width;
    int         len;
  } bus_byte_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;
  logic [7:0] LCD_DATA;

  int        checks = 0, failures = 0, cyc = 0, exp_low = 0;
  int        m_valid = 0, m_row = 0, m_col = 0;
  int        m_shadow [32];
  bus_byte_t mon_q[$], exp_q[$];
  bus_byte_t cur;
  logic      en_prev = 1'b0;

  lcd_char_writer_if wr_if ();

  lcd_char_writer #(
    .POWERUP_CYC(P_PWR), .SETUP_CYC(P_SET), .EN_CYC(P_EN),
    .CMD_WAIT_CYC(P_CMD), .CLEAR_WAIT_CYC(P_CLR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr_if),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_ON(LCD_ON),
    .LCD_BLON(LCD_BLON), .LCD_DATA(LCD_DATA)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: one record per completed EN pulse.
  always @(negedge clk) begin
    if (LCD_EN && !en_prev) begin
      cur.rs = LCD_RS; cur.data = LCD_DATA; cur.rise = cyc; cur.width = 0; cur.len = 0;
    end
    if (!LCD_EN && en_prev) begin
      cur.width = cyc - cur.rise;
      mon_q.push_back(cur);
    end
    en_prev = LCD_EN;
  end

  task automatic model_reset();
    m_valid = 0;
    for (int i = 0; i < 32; i++) m_shadow[i] = 32;
  endtask

  task automatic model_push(input logic rs, input logic [7:0] d, input int len);
    bus_byte_t b;
    b.rs = rs; b.data = d; b.rise = 0; b.width = P_EN; b.len = len;
    exp_q.push_back(b);
    exp_low += len;
  endtask

  task automatic model_op(input bit clr, input int row, input int col, input logic [7:0] ch);
    exp_q.delete();
    exp_low = 0;
    if (clr) begin
      model_push(1'b0, 8'h01, L_CLR);
      model_reset();
    end
`ifdef LCD_SHADOW_EN
    else if (m_shadow[row*16+col] == int'(ch)) exp_low = 1;
`endif
    else begin
      if (!(m_valid != 0 && m_row == row && m_col == col)) model_push(1'b0, 8'(128 + 64*row + col), L_CMD);
      model_push(1'b1, ch, L_CMD);
      m_shadow[row*16+col] = int'(ch);
      m_row = row;
      m_col = col + 1;
      m_valid = (col + 1 < 16) ? 1 : 0;
    end
  endtask

  // Called at a negedge with the DUT idle; drives one request and checks it against the model.
  task automatic do_write(input bit clr, input bit valid, input int row, input int col,
                          input logic [7:0] ch, input string tag);
    int low;
    bit done;
    model_op(clr, row, col, ch);
    checks++;
    if (wr_if.wr_ready !== 1'b1) begin
      failures++; $display("FAIL %s ready_before: got %b expected 1", tag, wr_if.wr_ready);
    end
    mon_q.delete();
    wr_if.clr_req = clr; wr_if.wr_valid = valid;
    wr_if.wr_row = 1'(row); wr_if.wr_col = 4'(col); wr_if.wr_char = ch;
    @(posedge clk); #1;
    wr_if.clr_req = 1'b0; wr_if.wr_valid = 1'b0;
    wr_if.wr_char = 8'($urandom); wr_if.wr_col = 4'($urandom);
    low = 0; done = 0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (wr_if.wr_ready) done = 1; else low++;
    end
    checks++;
    if (!done) begin failures++; $display("FAIL %s ready_timeout: got low>=%0d", tag, low); end
    checks++;
    if (low != exp_low) begin failures++; $display("FAIL %s ready_low: got %0d expected %0d", tag, low, exp_low); end
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      failures++; $display("FAIL %s byte_count: got %0d expected %0d", tag, mon_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (mon_q[i].rs !== exp_q[i].rs || mon_q[i].data !== exp_q[i].data) begin
          failures++;
          $display("FAIL %s byte%0d: got rs=%b data=%h expected rs=%b data=%h", tag, i,
                   mon_q[i].rs, mon_q[i].data, exp_q[i].rs, exp_q[i].data);
        end
        checks++;
        if (mon_q[i].width != exp_q[i].width) begin
          failures++; $display("FAIL %s en_width%0d: got %0d expected %0d", tag, i, mon_q[i].width, exp_q[i].width);
        end
        if (i > 0) begin
          checks++;
          if (mon_q[i].rise - mon_q[i-1].rise != exp_q[i-1].len) begin
            failures++; $display("FAIL %s byte_gap%0d: got %0d expected %0d", tag, i,
                                 mon_q[i].rise - mon_q[i-1].rise, exp_q[i-1].len);
          end
        end
      end
    end
  endtask

  task automatic test_powerup(input string tag);
    logic [7:0] init_bytes [4];
    int         init_lens  [4];
    int c0, k;
    bit done;
    init_bytes = '{8'h38, 8'h0C, 8'h01, 8'h06};
    init_lens  = '{L_CMD, L_CMD, L_CLR, L_CMD};
    @(negedge clk);
    reset_n = 1'b1;
    c0 = cyc;
    mon_q.delete();
    model_reset();
    done = 0; k = 0;
    while (!done && k < 2000) begin
      @(negedge clk);
      k = cyc - c0;
      if (wr_if.wr_ready) done = 1;
    end
    checks++;
    if (k != P_PWR + 1 + 3*L_CMD + L_CLR) begin
      failures++; $display("FAIL %s ready_rise: got %0d expected %0d", tag, k, P_PWR + 1 + 3*L_CMD + L_CLR);
    end
    checks++;
    if (mon_q.size() != 4) begin
      failures++; $display("FAIL %s init_count: got %0d expected 4", tag, mon_q.size());
    end else begin
      checks++;
      if (mon_q[0].rise - c0 != P_PWR + 1 + P_SET) begin
        failures++; $display("FAIL %s first_en: got %0d expected %0d", tag, mon_q[0].rise - c0, P_PWR + 1 + P_SET);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (mon_q[i].data !== init_bytes[i] || mon_q[i].rs !== 1'b0 || mon_q[i].width != P_EN) begin
          failures++; $display("FAIL %s init%0d: got rs=%b data=%h w=%0d expected rs=0 data=%h w=%0d",
                               tag, i, mon_q[i].rs, mon_q[i].data, mon_q[i].width, init_bytes[i], P_EN);
        end
        if (i > 0) begin
          checks++;
          if (mon_q[i].rise - mon_q[i-1].rise != init_lens[i-1]) begin
            failures++; $display("FAIL %s init_gap%0d: got %0d expected %0d", tag, i,
                                 mon_q[i].rise - mon_q[i-1].rise, init_lens[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_if.wr_ready, LCD_EN, LCD_RS, LCD_RW, LCD_ON, LCD_BLON, LCD_DATA} !== {6'b000011, 8'h00}) begin
      failures++; $display("FAIL reset_values: got rdy=%b en=%b rs=%b rw=%b on=%b bl=%b data=%h expected 0 0 0 0 1 1 00",
                           wr_if.wr_ready, LCD_EN, LCD_RS, LCD_RW, LCD_ON, LCD_BLON, LCD_DATA);
    end
    test_powerup("powerup");
  endtask

  task automatic test_positioning();
    do_write(0, 1, 1, 3, 8'h41, "addr_then_data");
    do_write(0, 1, 1, 4, 8'h42, "cursor_follow");
    do_write(0, 1, 0, 15, 8'h43, "col15");
    do_write(0, 1, 0, 0, 8'h44, "after_col15_row0");
    do_write(0, 1, 0, 15, 8'h45, "col15_again");
    do_write(0, 1, 1, 0, 8'h46, "after_col15_row1");
  endtask

  task automatic test_clear_priority();
    do_write(1, 1, 1, 1, 8'h47, "clear_with_write");
    do_write(0, 1, 1, 1, 8'h48, "write_after_clear");
  endtask

  task automatic test_random();
    int row, col;
    bit clr, valid;
    for (int n = 0; n < 24; n++) begin
      clr   = ($urandom_range(0, 7) == 0);
      valid = clr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid != 0 && $urandom_range(0, 1) == 1) begin
        row = m_row; col = m_col;
      end else begin
        row = $urandom_range(0, 1); col = $urandom_range(0, 15);
      end
      do_write(clr, valid, row, col, ($urandom_range(0, 3) == 0) ? 8'h20 : 8'($urandom), "random");
    end
  endtask

`ifdef LCD_SHADOW_EN
  task automatic test_shadow();
    do_write(0, 1, 0, 0, 8'h41, "shadow_first");
    do_write(0, 1, 0, 0, 8'h41, "shadow_repeat");
    do_write(1, 0, 0, 0, 8'h00, "shadow_clear");
    do_write(0, 1, 0, 0, 8'h20, "shadow_blank");
  endtask
`endif

  task automatic test_reset_mid_transfer();
    bit seen;
    wr_if.wr_valid = 1'b1; wr_if.wr_row = 1'b1; wr_if.wr_col = 4'd5; wr_if.wr_char = 8'h5A;
    @(posedge clk); #1;
    wr_if.wr_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (LCD_EN) seen = 1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL midreset_en_seen: got 0 expected 1"); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (LCD_EN !== 1'b0 || wr_if.wr_ready !== 1'b0) begin
      failures++; $display("FAIL midreset_en_drop: got en=%b rdy=%b expected 0 0", LCD_EN, wr_if.wr_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (LCD_EN !== 1'b0) begin failures++; $display("FAIL midreset_en_held: got %b expected 0", LCD_EN); end
    test_powerup("restart");
    do_write(0, 1, 0, 2, 8'h31, "after_restart");
  endtask

  initial begin
    wr_if.wr_valid = 1'b0; wr_if.clr_req = 1'b0;
    wr_if.wr_row = 1'b0; wr_if.wr_col = 4'd0; wr_if.wr_char = 8'h00;
    model_reset();
    test_reset();
    test_positioning();
    test_clear_priority();
    test_random();
`ifdef LCD_SHADOW_EN
    test_shadow();
`endif
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
